// File: rtl/mrd_pkg.sv
// ============================================================================
// mrd_pkg : shared types for the mixed-radix DFT source output buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

package mrd_pkg;

  localparam int DW = 36;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } mrd_obuf_entry_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } mrd_obuf_st_e;

endpackage

`default_nettype wire

// File: rtl/mrd_sfifo.sv
// ============================================================================
// mrd_sfifo : generic synchronous show-ahead FIFO with registered level/afull
// Revision: 1.0
// ============================================================================
`default_nettype none

module mrd_sfifo
  import mrd_pkg::*;
#(
  parameter int WIDTH    = 38,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     afull,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]     AFULL_LVL = (AW+1)'(AFULL_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      level_nxt;
  logic             do_wr;
  logic             do_rd;

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign do_rd = rd && !empty;
  // A read in the same cycle frees the slot the write lands in.
  assign do_wr = wr && (!full || do_rd);

  always_comb begin
    level_nxt = level;
    if (do_wr && !do_rd) begin
      level_nxt = level + (AW+1)'(1);
    end else if (!do_wr && do_rd) begin
      level_nxt = level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      afull <= 1'b0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + AW'(1);
      end
      if (do_rd) begin
        rptr <= rptr + AW'(1);
      end
      level <= level_nxt;
      afull <= (level_nxt >= AFULL_LVL);
    end
  end

  assign rdata = empty ? '0 : mem[rptr];

endmodule

`default_nettype wire

// File: rtl/mrd_source_obuf.sv
// ============================================================================
// mrd_source_obuf : frame tracker + FIFO between DFT source stage and consumer
// Optional frame-length check enabled by MRD_OBUF_LENCHK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mrd_source_obuf #(
  parameter int DW       = 36,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [DW-1:0]           in_data,
  input  logic [11:0]             dftpts,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [DW-1:0]           out_data,
  output logic                    afull,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    stray,
  output logic                    len_err,
  output logic                    frame_done
);

  import mrd_pkg::*;

  localparam int EW = DW + 2;

  mrd_obuf_st_e  state;
  logic          accept;
  logic          fifo_wr;
  logic          fifo_rd;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_wdata;
  logic [EW-1:0] fifo_rdata;

  // A beat belongs to a frame if it opens one or arrives while one is open.
  assign accept     = in_valid && (in_sop || state == IN_FRAME);
  assign fifo_rd    = !fifo_empty && out_ready;
  assign fifo_wr    = accept && (!fifo_full || fifo_rd);
  assign fifo_wdata = {in_sop, in_eop, in_data};
  assign out_valid  = !fifo_empty;

  mrd_sfifo #(
    .WIDTH    (EW),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (fifo_wr),
    .wdata (fifo_wdata),
    .rd    (fifo_rd),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .afull (afull),
    .level (level)
  );

  generate
    if (DW == mrd_pkg::DW) begin : g_pkg_entry
      mrd_obuf_entry_t head;
      assign head     = fifo_rdata;
      assign out_sop  = head.sop;
      assign out_eop  = head.eop;
      assign out_data = head.data;
    end else begin : g_raw_entry
      assign out_sop  = fifo_rdata[EW-1];
      assign out_eop  = fifo_rdata[EW-2];
      assign out_data = fifo_rdata[DW-1:0];
    end
  endgenerate

  // The tracker follows frame structure even when the FIFO drops a beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      overflow   <= 1'b0;
      stray      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (accept) begin
        state <= in_eop ? IDLE : IN_FRAME;
      end
      if (accept && !fifo_wr) begin
        overflow <= 1'b1;
      end
      stray      <= in_valid && !accept;
      frame_done <= fifo_rd && out_eop;
    end
  end

`ifdef MRD_OBUF_LENCHK_EN
  logic [11:0] beat_cnt;
  logic [11:0] beat_num;

  assign beat_num = in_sop ? 12'd1 : beat_cnt + 12'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      if (accept) begin
        beat_cnt <= beat_num;
      end
      len_err <= accept && ((in_sop && state == IN_FRAME) ||
                            (in_eop && beat_num != dftpts));
    end
  end
`else
  logic unused_dftpts;
  assign unused_dftpts = ^dftpts;
  assign len_err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mrd_source_obuf.sv
// ============================================================================
// tb_mrd_source_obuf : directed self-checking bench for mrd_source_obuf
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mrd_source_obuf;

`ifdef MRD_OBUF_LENCHK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic [35:0] in_data;
  logic [11:0] dftpts;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [35:0] out_data;
  logic        afull;
  logic [4:0]  level;
  logic        overflow;
  logic        stray;
  logic        len_err;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mrd_source_obuf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_data    (in_data),
    .dftpts     (dftpts),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_data   (out_data),
    .afull      (afull),
    .level      (level),
    .overflow   (overflow),
    .stray      (stray),
    .len_err    (len_err),
    .frame_done (frame_done)
  );

  function automatic logic [35:0] dpat(input int id, input int i);
    return {4'h0, 8'(id), 12'hC3C, 12'(i)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [35:0] d);
    in_valid = v;
    in_sop   = s;
    in_eop   = e;
    in_data  = d;
  endtask

  // Frame of n beats with the consumer always ready; each beat appears one cycle later.
  task automatic pass_frame(input int id, input int n, input int err_at);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, i == 0, i == n - 1, dpat(id, i));
      tick();
      chk("pf_valid", 64'(out_valid), 64'(1));
      chk("pf_data",  64'(out_data),  64'(dpat(id, i)));
      chk("pf_sop",   64'(out_sop),   64'(i == 0));
      chk("pf_eop",   64'(out_eop),   64'(i == n - 1));
      chk("pf_level", 64'(level),     64'(1));
      chk("pf_done",  64'(frame_done), 64'(0));
      chk("pf_lerr",  64'(len_err),   64'(LEN_EN && i == err_at));
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("pf_done_pulse", 64'(frame_done), 64'(1));
    chk("pf_empty",      64'(out_valid),  64'(0));
    chk("pf_level0",     64'(level),      64'(0));
    tick();
    chk("pf_done_clear", 64'(frame_done), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    dftpts    = 12'd12;
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();

    // Reset state
    chk("rst_valid",    64'(out_valid),  64'(0));
    chk("rst_sop",      64'(out_sop),    64'(0));
    chk("rst_eop",      64'(out_eop),    64'(0));
    chk("rst_data",     64'(out_data),   64'(0));
    chk("rst_afull",    64'(afull),      64'(0));
    chk("rst_level",    64'(level),      64'(0));
    chk("rst_overflow", 64'(overflow),   64'(0));
    chk("rst_stray",    64'(stray),      64'(0));
    chk("rst_lenerr",   64'(len_err),    64'(0));
    chk("rst_done",     64'(frame_done), 64'(0));
    rst_n = 1'b1;
    tick();

    // 12-beat frame, consumer always ready
    pass_frame(1, 12, -1);

    // 24-beat frame into a stalled consumer: 16 kept, 8 dropped
    dftpts    = 12'd24;
    out_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, i == 0, i == 23, dpat(2, i));
      tick();
      chk("bp_level", 64'(level),    64'((i < 16) ? i + 1 : 16));
      chk("bp_afull", 64'(afull),    64'(((i < 16) ? i + 1 : 16) >= 12));
      chk("bp_ovf",   64'(overflow), 64'(i >= 16));
      chk("bp_head",  64'(out_data), 64'(dpat(2, 0)));
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("dr_valid", 64'(out_valid), 64'(1));
      chk("dr_data",  64'(out_data),  64'(dpat(2, k)));
      chk("dr_sop",   64'(out_sop),   64'(k == 0));
      tick();
    end
    chk("dr_empty",   64'(out_valid), 64'(0));
    chk("dr_level",   64'(level),     64'(0));
    chk("dr_ovf_stk", 64'(overflow),  64'(1));
    chk("dr_afull",   64'(afull),     64'(0));

    // Full FIFO with simultaneous read and write
    do_reset();
    tick();
    chk("r2_ovf", 64'(overflow), 64'(0));
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i == 0, 1'b0, dpat(3, i));
      tick();
    end
    chk("fl_level", 64'(level), 64'(16));
    chk("fl_afull", 64'(afull), 64'(1));
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, dpat(3, 16));
    tick();
    chk("rw_level", 64'(level),    64'(16));
    chk("rw_ovf",   64'(overflow), 64'(0));
    chk("rw_head",  64'(out_data), 64'(dpat(3, 1)));
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, dpat(3, 17));
    tick();
    chk("fn_ovf",   64'(overflow), 64'(1));
    chk("fn_level", 64'(level),    64'(16));

    // Stray beat in IDLE
    do_reset();
    tick();
    drive(1'b1, 1'b0, 1'b0, dpat(4, 0));
    tick();
    chk("st_pulse", 64'(stray), 64'(1));
    chk("st_level", 64'(level), 64'(0));
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("st_clear", 64'(stray), 64'(0));
    chk("st_level2", 64'(level), 64'(0));

    // Short frame: eop on beat 10 of 12
    dftpts = 12'd12;
    pass_frame(5, 10, 9);

    // Second sop mid-frame restarts the frame
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, i == 0 || i == 3, i == 14, dpat(8, i));
      tick();
      chk("s2_data", 64'(out_data), 64'(dpat(8, i)));
      chk("s2_sop",  64'(out_sop),  64'(i == 0 || i == 3));
      chk("s2_lerr", 64'(len_err),  64'(LEN_EN && i == 3));
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("s2_done", 64'(frame_done), 64'(1));
    chk("s2_lerr_end", 64'(len_err), 64'(0));
    tick();

    // Reset mid-frame with overflow set and 5 beats buffered
    out_ready = 1'b0;
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, i == 0, 1'b0, dpat(6, i));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("mr_ovf_pre", 64'(overflow), 64'(1));
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
    end
    out_ready = 1'b0;
    chk("mr_level5", 64'(level),    64'(5));
    chk("mr_head",   64'(out_data), 64'(dpat(6, 11)));
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, dpat(6, 21));
    tick();
    chk("mr_level", 64'(level),     64'(0));
    chk("mr_valid", 64'(out_valid), 64'(0));
    chk("mr_ovf",   64'(overflow),  64'(0));
    chk("mr_data",  64'(out_data),  64'(0));
    rst_n = 1'b1;
    tick();
    chk("mr_stray", 64'(stray), 64'(1));
    chk("mr_lvl_post", 64'(level), 64'(0));
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    pass_frame(7, 12, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
